// File: rtl/sync_fifo_ctrl.sv
// Pointer/flag controller for a synchronous FIFO wrapped around dp_ram (port A writes, port B reads).
// Optional feature macro: FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
module sync_fifo_ctrl #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    output logic                  full,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [WIDTH-1:0]      ram_data_a,
    output logic                  ram_we_b,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    input  logic [WIDTH-1:0]      ram_data_b
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    // One extra wrap bit distinguishes full from empty when the low bits match.
    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic                wr_acc;
    logic                rd_acc;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                    (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign count  = wr_ptr - rd_ptr;

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    assign ram_we_a   = wr_acc;
    assign ram_addr_a = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_data_a = wr_data;
    assign ram_we_b   = 1'b0;
    assign ram_addr_b = rd_ptr[ADDR_WIDTH-1:0];
    assign rd_data    = ram_data_b;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
            rd_valid <= rd_acc;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow  | (wr_en & full);
            underflow <= underflow | (rd_en & empty);
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: directed scenarios plus random traffic,
// compared against a queue-based FIFO model; includes a behavioural dp_ram.
module tb_sync_fifo_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             full;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             empty;
    logic [AW:0]      count;
    logic             ram_we_a;
    logic [AW-1:0]    ram_addr_a;
    logic [WIDTH-1:0] ram_data_a;
    logic             ram_we_b;
    logic [AW-1:0]    ram_addr_b;
    logic [WIDTH-1:0] ram_data_b;
`ifdef FIFO_ERR_FLAGS_EN
    logic             overflow;
    logic             underflow;
`endif

    sync_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .empty      (empty),
        .count      (count),
        .ram_we_a   (ram_we_a),
        .ram_addr_a (ram_addr_a),
        .ram_data_a (ram_data_a),
        .ram_we_b   (ram_we_b),
        .ram_addr_b (ram_addr_b),
        .ram_data_b (ram_data_b)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow   (overflow),
        .underflow  (underflow)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural dp_ram: synchronous write on A, registered read on B.
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
        ram_data_b <= mem[ram_addr_b];
    end

    // Reference model: a queue of stored words plus running push/pop totals.
    logic [WIDTH-1:0] model_q [$];
    int               n_pushed;
    int               n_popped;
    logic             exp_valid;
    logic [WIDTH-1:0] exp_data;
    logic             exp_ovf;
    logic             exp_udf;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        n_pushed  = 0;
        n_popped  = 0;
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check({tag, ".empty"},    32'(empty),    32'(model_q.size() == 0));
        check({tag, ".full"},     32'(full),     32'(model_q.size() == DEPTH));
        check({tag, ".count"},    32'(count),    32'(model_q.size()));
        check({tag, ".rd_valid"}, 32'(rd_valid), 32'(exp_valid));
        if (exp_valid) check({tag, ".rd_data"}, 32'(rd_data), 32'(exp_data));
`ifdef FIFO_ERR_FLAGS_EN
        check({tag, ".overflow"},  32'(overflow),  32'(exp_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(exp_udf));
`endif
    endtask

    // One clock cycle: called at a negedge, returns at the next negedge.
    task automatic step(input logic wr, input logic rd, input logic [WIDTH-1:0] d);
        logic wacc, racc;
        wr_en   = wr;
        rd_en   = rd;
        wr_data = d;
        wacc = wr && (model_q.size() < DEPTH);
        racc = rd && (model_q.size() > 0);
        #1;
        check("ram_we_a", 32'(ram_we_a), 32'(wacc));
        check("ram_we_b", 32'(ram_we_b), 32'd0);
        if (wacc) begin
            check("ram_addr_a", 32'(ram_addr_a), 32'(n_pushed % DEPTH));
            check("ram_data_a", 32'(ram_data_a), 32'(d));
        end
        if (racc) check("ram_addr_b", 32'(ram_addr_b), 32'(n_popped % DEPTH));
        @(posedge clk);
        if (wr && model_q.size() == DEPTH) exp_ovf = 1'b1;
        if (rd && model_q.size() == 0)     exp_udf = 1'b1;
        exp_valid = racc;
        if (racc) begin
            exp_data = model_q.pop_front();
            n_popped++;
        end
        if (wacc) begin
            model_q.push_back(d);
            n_pushed++;
        end
        @(negedge clk);
        check_status("step");
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        model_reset();

        // 1: reset state
        repeat (2) @(negedge clk);
        check_status("reset");
        check("reset.ram_we_a", 32'(ram_we_a), 32'd0);
        check("reset.ram_we_b", 32'(ram_we_b), 32'd0);
        rst_n = 1'b1;

        // 2: fill / drain
        step(1, 0, 8'hA5);
        step(1, 0, 8'h5A);
        step(1, 0, 8'h3C);
        check("fill3.count", 32'(count), 32'd3);
        repeat (3) step(0, 1, '0);
        step(0, 0, '0);

        // 3: full, rejected push, drain in order
        for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(i));
        check("full.flag", 32'(full), 32'd1);
        step(1, 0, 8'hFF);
        check("full.count_after_reject", 32'(count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) step(0, 1, '0);
        step(0, 1, '0);  // pop on empty is rejected

        // 4: wrap-around across pointer rollover
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h10 * r + i));
            for (int i = 0; i < 5; i++) step(0, 1, '0);
        end
        check("wrap.empty", 32'(empty), 32'd1);

        // 5: simultaneous push+pop at count=4, then on empty
        for (int i = 0; i < 4; i++) step(1, 0, 8'(8'hC0 + i));
        for (int i = 0; i < 6; i++) step(1, 1, 8'(8'hD0 + i));
        check("simul.count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) step(0, 1, '0);
        step(1, 1, 8'hE1);
        check("simul_empty.count", 32'(count), 32'd1);
        check("simul_empty.rd_valid", 32'(rd_valid), 32'd0);
        step(0, 1, '0);
        step(0, 0, '0);

        // 6: mid-operation reset with a read in flight
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h60 + i));
        step(0, 1, '0);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_status("midrst");
        #1 rst_n = 1'b1;
        step(1, 0, 8'h77);
        step(0, 1, '0);
        check("midrst.rd_data", 32'(rd_data), 32'h77);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic w, r;
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 50);
            step(w, r, 8'($urandom));
        end
        for (int i = 0; i <= DEPTH; i++) step(0, 1, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
